// File: rtl/smc_ahb_mcs_if18.sv
// AHB-lite slave front end for the static memory controller: decodes one of
// NUM_CS banks from the address, registers the address phase, captures write
// data in the data phase and produces the two-cycle ERROR response.
module smc_ahb_mcs_if18 #(
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned CS_LSB = 24,
    parameter int unsigned DATA_W = 32
) (
    input  logic              hclk18,
    input  logic              n_sys_reset18,
    input  logic              hsel18,
    input  logic [31:0]       haddr18,
    input  logic [1:0]        htrans18,
    input  logic              hwrite18,
    input  logic [2:0]        hsize18,
    input  logic [DATA_W-1:0] hwdata18,
    input  logic              hready18,
    input  logic [NUM_CS-1:0] cs_enable18,
    input  logic              smc_done18,
    input  logic              mac_done18,
    input  logic [DATA_W-1:0] read_data18,
    output logic [DATA_W-1:0] smc_hrdata18,
    output logic              smc_hready18,
    output logic [1:0]        smc_hresp18,
    output logic              smc_valid18,
    output logic              new_access18,
    output logic [NUM_CS-1:0] cs18,
    output logic [31:0]       addr18,
    output logic [1:0]        xfer_size18,
    output logic              n_read18,
    output logic [DATA_W-1:0] write_data18
);

    localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam logic [2:0]  MAX_SIZE = 3'($clog2(DATA_W / 8));

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              sample;
    logic              misalign;
    logic              size_err;
    logic              access_err;
    logic              decode_en;
    logic              complete;
    logic [CS_W-1:0]   bank;
    logic [NUM_CS-1:0] bank_onehot;
    logic              unused_htrans;

    // BUSY and IDLE differ only in bit 0; neither starts an access.
    assign unused_htrans = htrans18[0];
    assign sample        = hsel18 & hready18 & htrans18[1];
    assign smc_hrdata18  = read_data18;

    // Bank decode and error classification of the current address phase.
    // An out-of-range bank index matches no one-hot bit, so it is caught by
    // the same enable check as a disabled bank.
    always_comb begin
        bank = (NUM_CS > 1) ? haddr18[CS_LSB +: CS_W] : '0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            bank_onehot[i] = (bank == CS_W'(i));
        end
        case (hsize18)
            3'd1:    misalign = haddr18[0];
            3'd2:    misalign = |haddr18[1:0];
            3'd3:    misalign = |haddr18[2:0];
            default: misalign = 1'b0;
        endcase
        size_err   = (hsize18 > MAX_SIZE);
        access_err = misalign | size_err | ~|(bank_onehot & cs_enable18);
    end

    // State register.
    always_ff @(posedge hclk18 or negedge n_sys_reset18) begin
        if (!n_sys_reset18) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and response outputs; decode_en marks cycles that may sample.
    always_comb begin
        state_next   = state;
        smc_hready18 = 1'b1;
        smc_hresp18  = 2'b00;
        decode_en    = 1'b0;
        complete     = 1'b0;
        case (state)
            ST_IDLE: begin
                decode_en = 1'b1;
            end
            ST_ACCESS: begin
                smc_hready18 = smc_done18 & mac_done18;
                complete     = smc_done18 & mac_done18;
                decode_en    = complete;
                if (complete) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR1: begin
                smc_hready18 = 1'b0;
                smc_hresp18  = 2'b01;
                state_next   = ST_ERR2;
            end
            ST_ERR2: begin
                smc_hresp18 = 2'b01;
                decode_en   = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (decode_en && sample) begin
            state_next = access_err ? ST_ERR1 : ST_ACCESS;
        end
        smc_valid18 = decode_en & sample & ~access_err;
    end

    // Address-phase latch, start pulse and bank select.
    always_ff @(posedge hclk18 or negedge n_sys_reset18) begin
        if (!n_sys_reset18) begin
            new_access18 <= 1'b0;
            cs18         <= '0;
            addr18       <= '0;
            xfer_size18  <= '0;
            n_read18     <= 1'b1;
        end else if (smc_valid18) begin
            new_access18 <= 1'b1;
            cs18         <= bank_onehot;
            addr18       <= haddr18;
            xfer_size18  <= hsize18[1:0];
            n_read18     <= hwrite18;
        end else begin
            new_access18 <= 1'b0;
            if (complete) begin
                cs18 <= '0;
            end
        end
    end

    // Write data is on the bus during the first access cycle.
    always_ff @(posedge hclk18 or negedge n_sys_reset18) begin
        if (!n_sys_reset18) begin
            write_data18 <= '0;
        end else if (new_access18 && n_read18) begin
            write_data18 <= hwdata18;
        end
    end

endmodule

// File: doc/smc_ahb_mcs_if18.md
# smc_ahb_mcs_if18

Parametrised multi-bank AHB-lite slave front end for the static memory controller. It decodes up to NUM_CS external banks from the address, registers address/control at the address phase, and captures write data in the data phase. It generates the proper two-cycle AHB ERROR response for misaligned, oversized or disabled-bank accesses. It sits between the AHB fabric and the SMC state machine/MAC, replacing the single-bank, combinational-address front end.

## Interface
- NUM_CS, 4: number of external banks, 1..8.
- CS_LSB, 24: lowest haddr bit of the bank index field. The field is haddr18[CS_LSB +: CS_W], with CS_W = max(1, clog2(NUM_CS)).
- DATA_W, 32: data bus width, 32 or 64.

Ports:
- hclk18  in  1  AHB clock.
- n_sys_reset18  in  1  asynchronous, active-low reset.
- hsel18  in  1  slave select.
- haddr18  in  32  AHB address.
- htrans18  in  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
- hwrite18  in  1  1 = write.
- hsize18  in  3  transfer size.
- hwdata18  in  DATA_W  write data.
- hready18  in  1  muxed bus ready.
- cs_enable18  in  NUM_CS  per-bank enable; an access to a disabled bank is an error.
- smc_done18  in  1  SMC last cycle of access.
- mac_done18  in  1  MAC all transfers complete.
- read_data18  in  DATA_W  read data from the SMC data path.
- smc_hrdata18  out  DATA_W  read_data18 passed through combinationally.
- smc_hready18  out  1  slave ready.
- smc_hresp18  out  2  response (OKAY 00, ERROR 01).
- smc_valid18  out  1  combinational: a valid, error-free access is sampled this cycle.
- new_access18  out  1  registered one-cycle start pulse to the SMC.
- cs18  out  NUM_CS  registered one-hot bank select; held for the whole access.
- addr18  out  32  registered address.
- xfer_size18  out  2  registered hsize18[1:0].
- n_read18  out  1  registered hwrite18 (0 = read).
- write_data18  out  DATA_W  registered write data.

## Operation
- Sample condition S = hsel18 & hready18 & htrans18[1]. IDLE and BUSY transfers are never errors and never start an access.
- Error on S when any of the following holds:
  - misalignment: the haddr18 low bits are nonzero for the given size (half: bit 0; word: bits 1:0; dword: bits 2:0);
  - hsize18 exceeds clog2(DATA_W/8);
  - the decoded bank index is ≥ NUM_CS;
  - cs_enable18 for the decoded bank is 0.
- smc_valid18 = S & ~error. It is evaluated only in the IDLE and ERR2 states and in the ACCESS completion cycle; it is 0 otherwise.
- State machine: IDLE, ACCESS, ERR1, ERR2.
  - IDLE: smc_hready18 = 1, hresp OKAY.
    - S & ~error → ACCESS. In the same edge, latch addr18, xfer_size18, n_read18 and cs18 (one-hot), and assert new_access18 for one cycle.
    - S & error → ERR1.
    - Otherwise, stay in IDLE.
  - ACCESS: smc_hready18 = smc_done18 & mac_done18. The first ACCESS cycle captures hwdata18 into write_data18 when n_read18 = 1. Completion is the cycle where smc_hready18 = 1:
    - valid S → stay in ACCESS with the new latch and a new_access18 pulse (back-to-back);
    - S & error → ERR1;
    - else → IDLE, and cs18 clears to 0.
  - ERR1: smc_hready18 = 0, smc_hresp18 = ERROR. → ERR2.
  - ERR2: smc_hready18 = 1, smc_hresp18 = ERROR. Decodes exactly like IDLE, so a transfer issued by the master is accepted, not dropped.
- NUM_CS = 1: the bank index is forced to 0, and only cs_enable18[0] is checked.
- smc_hrdata18 is valid only during the ACCESS completion cycle of a read.

## Timing
- Reset values: state IDLE, smc_hready18 1, smc_hresp18 00, smc_valid18 0 when inputs are idle, new_access18 0, cs18 0, addr18 0, xfer_size18 0, n_read18 1, write_data18 0.
- Latency:
  - address phase sampled at edge N → new_access18/cs18/addr18 valid in cycle N+1;
  - write_data18 valid from N+2;
  - minimum access is 2 cycles (smc_done18 & mac_done18 high in cycle N+1 gives zero wait states).
- Error response is exactly two cycles: hready low in ERR1, high in ERR2, hresp ERROR in both.
- smc_done18 without mac_done18 keeps the wait; done inputs are ignored outside ACCESS.
- Reset asserted mid-access: all registers return to reset values immediately; the SMC must be reset by the same signal.

## Test plan
- Zero-wait word read: NUM_CS=4, NONSEQ read of 0x0100_0010, done pair high in the next cycle → cs18=0010, new_access18 one pulse, hready high in cycle 2, hrdata = read_data18.
- Write with 3 wait states to bank 3 (0x0300_0000), hwdata 0xA5A5_5A5A → write_data18 = 0xA5A5_5A5A from N+2; hready low for 3 cycles, then high.
- Misaligned word at 0x0000_0002 → smc_valid18 0, no new_access18; hready 0/1 with hresp ERROR/ERROR; state returns to IDLE.
- Disabled bank: cs_enable18=1101, access to bank 1 → two-cycle ERROR; the same access with cs_enable18=1111 → OKAY.
- Back-to-back: a NONSEQ presented during the completion cycle → second new_access18 the next cycle with no idle gap; also a NONSEQ presented in ERR2 is accepted.
- Reset asserted in ACCESS with hready low → outputs at reset values asynchronously; after release, a new read completes normally.
